// File: rtl/axi_rd_arbiter_pkg.sv
// Shared types and AXI constants for the 2:1 AXI4 read-channel arbiter.
package axi_rd_arbiter_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_ADDR = 2'd1;
  localparam state_t ST_DATA = 2'd2;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'b010;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_EXOKAY = 2'b01,
    RESP_SLVERR = 2'b10,
    RESP_DECERR = 2'b11
  } resp_t;

  // True on the handshake of the final beat of a burst.
  function automatic logic last_beat_done(input logic valid, input logic ready, input logic last);
    return valid & ready & last;
  endfunction

endpackage

// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read channels (AR + R); master drives AR and rready, slave drives arready and R.
interface axi_rd_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [ID_W-1:0]   arid;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic [ID_W-1:0]   rid;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst, rready,
    input  arready, rvalid, rdata, rresp, rlast, rid
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
    output arready, rvalid, rdata, rresp, rlast, rid
  );
endinterface

// File: rtl/axi_rd_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one not served last.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       grant
);
  always_comb begin
    grant = last_grant;
    case (req)
      2'b01:   grant = 1'b0;
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_grant;
      default: grant = last_grant;
    endcase
  end
endmodule

// File: rtl/axi_rd_arbiter.sv
// 2:1 AXI4 read arbiter: icache (m0) and LSU (m1) share one downstream read port,
// one whole transaction at a time, with no buffering on AR or R.
module axi_rd_arbiter
  import axi_rd_arbiter_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  axi_rd_if.slave  m0,
  axi_rd_if.slave  m1,
  axi_rd_if.master s
);
  state_t state_reg, state_next;
  logic   grant_reg, grant_next;
  logic   last_grant_reg, last_grant_next;
  logic   pick;
  logic   in_addr;
  logic   in_data;
  logic [1:0] req;

  assign req = {m1.arvalid, m0.arvalid};

  rr_arb2 u_rr_arb2 (
    .req        (req),
    .last_grant (last_grant_reg),
    .grant      (pick)
  );

  // Handshake outputs are gated by rst so they drop in the reset cycle itself.
  assign in_addr = (state_reg == ST_ADDR) && !rst;
  assign in_data = (state_reg == ST_DATA) && !rst;

  assign s.arvalid = in_addr && (grant_reg ? m1.arvalid : m0.arvalid);
  assign s.araddr  = grant_reg ? m1.araddr  : m0.araddr;
  assign s.arid    = grant_reg ? m1.arid    : m0.arid;
  assign s.arlen   = grant_reg ? m1.arlen   : m0.arlen;
  assign s.arsize  = grant_reg ? m1.arsize  : m0.arsize;
  assign s.arburst = grant_reg ? m1.arburst : m0.arburst;
  assign s.rready  = in_data && (grant_reg ? m1.rready : m0.rready);

  assign m0.arready = in_addr && !grant_reg && s.arready;
  assign m1.arready = in_addr &&  grant_reg && s.arready;

  // R payload fans out to both masters; only rvalid is steered by the grant.
  assign m0.rvalid = in_data && !grant_reg && s.rvalid;
  assign m0.rdata  = s.rdata;
  assign m0.rresp  = s.rresp;
  assign m0.rlast  = s.rlast;
  assign m0.rid    = s.rid;

  assign m1.rvalid = in_data && grant_reg && s.rvalid;
  assign m1.rdata  = s.rdata;
  assign m1.rresp  = s.rresp;
  assign m1.rlast  = s.rlast;
  assign m1.rid    = s.rid;

  always_comb begin
    state_next      = state_reg;
    grant_next      = grant_reg;
    last_grant_next = last_grant_reg;
    case (state_reg)
      ST_IDLE: begin
        if (|req) begin
          grant_next = pick;
          state_next = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (s.arvalid && s.arready) state_next = ST_DATA;
      end
      ST_DATA: begin
        if (last_beat_done(s.rvalid, s.rready, s.rlast)) begin
          state_next      = ST_IDLE;
          last_grant_next = grant_reg;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      grant_reg      <= 1'b0;
      last_grant_reg <= 1'b1;
    end else begin
      state_reg      <= state_next;
      grant_reg      <= grant_next;
      last_grant_reg <= last_grant_next;
    end
  end
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays both upstream masters and the downstream slave.
module tb_axi_rd_arbiter;
  import axi_rd_arbiter_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m0_if ();
  axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) m1_if ();
  axi_rd_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) s_if ();

  axi_rd_arbiter dut (
    .clk (clk),
    .rst (rst),
    .m0  (m0_if),
    .m1  (m1_if),
    .s   (s_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_bus();
    m0_if.arvalid = 0; m0_if.araddr = '0; m0_if.arid = '0; m0_if.arlen = '0;
    m0_if.arsize = SIZE_4B; m0_if.arburst = BURST_INCR; m0_if.rready = 0;
    m1_if.arvalid = 0; m1_if.araddr = '0; m1_if.arid = '0; m1_if.arlen = '0;
    m1_if.arsize = SIZE_4B; m1_if.arburst = BURST_INCR; m1_if.rready = 0;
    s_if.arready = 0; s_if.rvalid = 0; s_if.rdata = '0; s_if.rresp = RESP_OKAY;
    s_if.rlast = 0; s_if.rid = '0;
  endtask

  task automatic do_reset();
    idle_bus();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic set_beat(input logic [31:0] data, input logic [1:0] resp, input logic last,
                          input logic [3:0] id);
    s_if.rvalid = 1; s_if.rdata = data; s_if.rresp = resp; s_if.rlast = last; s_if.rid = id;
  endtask

  task automatic test_reset();
    idle_bus();
    rst = 1;
    m0_if.arvalid = 1; m1_if.arvalid = 1;
    @(negedge clk);
    @(negedge clk);
    #1;
    tests++; if (dut.state_reg !== ST_IDLE) begin fails++; $display("FAIL reset_state: got %0d want %0d", dut.state_reg, ST_IDLE); end
    tests++; if (dut.last_grant_reg !== 1'b1) begin fails++; $display("FAIL reset_last_grant: got %0b want 1", dut.last_grant_reg); end
    tests++; if ({s_if.arvalid, s_if.rready, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid} !== 6'b0) begin
      fails++; $display("FAIL reset_outputs: got %06b want 000000",
        {s_if.arvalid, s_if.rready, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid}); end
    rst = 0;
    #1;
    tests++; if ({s_if.arvalid, m0_if.arready, m1_if.arready} !== 3'b0) begin
      fails++; $display("FAIL reset_cycle_after: got %03b want 000", {s_if.arvalid, m0_if.arready, m1_if.arready}); end
    @(negedge clk);
    #1;
    tests++; if (dut.grant_reg !== 1'b0) begin fails++; $display("FAIL reset_first_tie: grant got %0b want 0", dut.grant_reg); end
    $display("[TB] test_reset: reset state and first tie checked");
  endtask

  task automatic test_m0_only();
    do_reset();
    m0_if.arvalid = 1; m0_if.araddr = 32'h8000_0000; m0_if.arid = 4'h3; m0_if.arlen = 8'd3;
    #1;
    tests++; if (s_if.arvalid !== 1'b0) begin fails++; $display("FAIL m0_bubble: s_arvalid got %0b want 0", s_if.arvalid); end
    @(negedge clk);
    s_if.arready = 1;
    #1;
    tests++; if (s_if.arvalid !== 1'b1) begin fails++; $display("FAIL m0_s_arvalid: got %0b want 1", s_if.arvalid); end
    tests++; if (s_if.araddr !== 32'h8000_0000) begin fails++; $display("FAIL m0_s_araddr: got %08h want 80000000", s_if.araddr); end
    tests++; if (s_if.arlen !== 8'd3) begin fails++; $display("FAIL m0_s_arlen: got %0d want 3", s_if.arlen); end
    tests++; if ({m0_if.arready, m1_if.arready} !== 2'b10) begin fails++; $display("FAIL m0_arready: got %02b want 10", {m0_if.arready, m1_if.arready}); end
    @(negedge clk);
    m0_if.arvalid = 0; s_if.arready = 0; m0_if.rready = 1;
    for (int i = 0; i < 4; i++) begin
      set_beat(32'hA000_0000 + 32'(i), RESP_OKAY, (i == 3), 4'h3);
      #1;
      tests++; if (m0_if.rvalid !== 1'b1 || m0_if.rdata !== 32'hA000_0000 + 32'(i)) begin
        fails++; $display("FAIL m0_beat%0d: rvalid=%0b rdata=%08h want 1/%08h", i, m0_if.rvalid, m0_if.rdata, 32'hA000_0000 + 32'(i)); end
      tests++; if (m1_if.rvalid !== 1'b0 || s_if.rready !== 1'b1) begin
        fails++; $display("FAIL m0_beat%0d_steer: m1_rvalid=%0b s_rready=%0b want 0/1", i, m1_if.rvalid, s_if.rready); end
      @(negedge clk);
    end
    s_if.rvalid = 0; s_if.rlast = 0;
    #1;
    tests++; if (dut.state_reg !== ST_IDLE) begin fails++; $display("FAIL m0_end_idle: state got %0d want %0d", dut.state_reg, ST_IDLE); end
    $display("[TB] test_m0_only: 4-beat burst at 80000000 to m0");
  endtask

  task automatic test_tie();
    do_reset();
    m0_if.arvalid = 1; m0_if.araddr = 32'h0000_1000;
    m1_if.arvalid = 1; m1_if.araddr = 32'h0000_2000;
    @(negedge clk);
    s_if.arready = 1;
    #1;
    tests++; if (s_if.araddr !== 32'h0000_1000 || m0_if.arready !== 1'b1 || m1_if.arready !== 1'b0) begin
      fails++; $display("FAIL tie1_m0_first: araddr=%08h arready m0/m1=%0b%0b want 00001000/10", s_if.araddr, m0_if.arready, m1_if.arready); end
    @(negedge clk);
    m0_if.arvalid = 0; s_if.arready = 0; m0_if.rready = 1; m1_if.rready = 1;
    set_beat(32'h1111_1111, RESP_OKAY, 1'b1, 4'h0);
    #1;
    tests++; if (m0_if.rvalid !== 1'b1 || m1_if.rvalid !== 1'b0) begin
      fails++; $display("FAIL tie1_beat: m0/m1 rvalid=%0b%0b want 10", m0_if.rvalid, m1_if.rvalid); end
    @(negedge clk);
    s_if.rvalid = 0;
    @(negedge clk);
    s_if.arready = 1;
    #1;
    tests++; if (s_if.araddr !== 32'h0000_2000 || m1_if.arready !== 1'b1 || m0_if.arready !== 1'b0) begin
      fails++; $display("FAIL tie1_m1_second: araddr=%08h arready m0/m1=%0b%0b want 00002000/01", s_if.araddr, m0_if.arready, m1_if.arready); end
    @(negedge clk);
    m1_if.arvalid = 0; s_if.arready = 0;
    set_beat(32'h2222_2222, RESP_OKAY, 1'b1, 4'h0);
    #1;
    tests++; if (m1_if.rvalid !== 1'b1 || m0_if.rvalid !== 1'b0 || m1_if.rdata !== 32'h2222_2222) begin
      fails++; $display("FAIL tie1_m1_beat: m0/m1 rvalid=%0b%0b rdata=%08h want 01/22222222", m0_if.rvalid, m1_if.rvalid, m1_if.rdata); end
    @(negedge clk);
    s_if.rvalid = 0;
    m0_if.arvalid = 1; m1_if.arvalid = 1;
    @(negedge clk);
    #1;
    tests++; if (s_if.araddr !== 32'h0000_1000 || s_if.arvalid !== 1'b1) begin
      fails++; $display("FAIL tie2_m0: araddr=%08h arvalid=%0b want 00001000/1", s_if.araddr, s_if.arvalid); end
    $display("[TB] test_tie: m0 then m1, next tie to m0");
  endtask

  task automatic test_blocked_request();
    do_reset();
    m0_if.arvalid = 1; m0_if.araddr = 32'h0000_3000; m0_if.arlen = 8'd1;
    @(negedge clk);
    s_if.arready = 1;
    @(negedge clk);
    m0_if.arvalid = 0; s_if.arready = 1; m0_if.rready = 1;
    m1_if.arvalid = 1; m1_if.araddr = 32'h0000_4000;
    for (int i = 0; i < 2; i++) begin
      set_beat(32'h3000_0000 + 32'(i), RESP_OKAY, (i == 1), 4'h0);
      #1;
      tests++; if (m1_if.arready !== 1'b0 || s_if.arvalid !== 1'b0) begin
        fails++; $display("FAIL blocked_beat%0d: m1_arready=%0b s_arvalid=%0b want 0/0", i, m1_if.arready, s_if.arvalid); end
      @(negedge clk);
    end
    s_if.rvalid = 0; s_if.rlast = 0;
    #1;
    tests++; if (s_if.arvalid !== 1'b0 || m1_if.arready !== 1'b0) begin
      fails++; $display("FAIL blocked_idle: s_arvalid=%0b m1_arready=%0b want 0/0", s_if.arvalid, m1_if.arready); end
    @(negedge clk);
    #1;
    tests++; if (s_if.arvalid !== 1'b1 || s_if.araddr !== 32'h0000_4000 || m1_if.arready !== 1'b1) begin
      fails++; $display("FAIL blocked_m1_issue: arvalid=%0b araddr=%08h m1_arready=%0b want 1/00004000/1", s_if.arvalid, s_if.araddr, m1_if.arready); end
    $display("[TB] test_blocked_request: m1 waited behind m0 burst");
  endtask

  task automatic test_backpressure();
    do_reset();
    m0_if.arvalid = 1; m0_if.araddr = 32'h0000_5000; m0_if.arlen = 8'd0;
    @(negedge clk);
    s_if.arready = 1;
    @(negedge clk);
    m0_if.arvalid = 0; s_if.arready = 0; m0_if.rready = 0;
    set_beat(32'h5555_AAAA, RESP_OKAY, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (s_if.rready !== 1'b0 || m0_if.rvalid !== 1'b1 || dut.state_reg !== ST_DATA) begin
        fails++; $display("FAIL bp_hold%0d: s_rready=%0b m0_rvalid=%0b state=%0d want 0/1/%0d", i, s_if.rready, m0_if.rvalid, dut.state_reg, ST_DATA); end
      @(negedge clk);
    end
    m0_if.rready = 1;
    #1;
    tests++; if (s_if.rready !== 1'b1 || m0_if.rdata !== 32'h5555_AAAA) begin
      fails++; $display("FAIL bp_accept: s_rready=%0b rdata=%08h want 1/5555AAAA", s_if.rready, m0_if.rdata); end
    @(negedge clk);
    s_if.rvalid = 0;
    #1;
    tests++; if (dut.state_reg !== ST_IDLE) begin fails++; $display("FAIL bp_end_idle: state got %0d want %0d", dut.state_reg, ST_IDLE); end
    $display("[TB] test_backpressure: beat held 3 cycles then accepted");
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_if.arvalid = 1; m0_if.araddr = 32'h0000_6000; m0_if.arlen = 8'd3;
    @(negedge clk);
    s_if.arready = 1;
    @(negedge clk);
    m0_if.arvalid = 0; s_if.arready = 0; m0_if.rready = 1;
    for (int i = 0; i < 2; i++) begin
      set_beat(32'h6000_0000 + 32'(i), RESP_OKAY, 1'b0, 4'h0);
      @(negedge clk);
    end
    set_beat(32'h6000_0002, RESP_OKAY, 1'b0, 4'h0);
    rst = 1;
    #1;
    tests++; if (m0_if.rvalid !== 1'b0 || s_if.rready !== 1'b0) begin
      fails++; $display("FAIL rstmid_during: m0_rvalid=%0b s_rready=%0b want 0/0", m0_if.rvalid, s_if.rready); end
    @(negedge clk);
    rst = 0;
    #1;
    tests++; if (dut.state_reg !== ST_IDLE) begin fails++; $display("FAIL rstmid_state: got %0d want %0d", dut.state_reg, ST_IDLE); end
    tests++; if ({s_if.arvalid, s_if.rready, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid} !== 6'b0) begin
      fails++; $display("FAIL rstmid_outputs: got %06b want 000000",
        {s_if.arvalid, s_if.rready, m0_if.arready, m1_if.arready, m0_if.rvalid, m1_if.rvalid}); end
    s_if.rvalid = 0;
    $display("[TB] test_reset_mid: burst abandoned after 2 of 4 beats");
  endtask

  task automatic test_err_single();
    do_reset();
    m1_if.arvalid = 1; m1_if.araddr = 32'h0000_7000; m1_if.arid = 4'h5; m1_if.arlen = 8'd0;
    @(negedge clk);
    s_if.arready = 1;
    #1;
    tests++; if (s_if.arid !== 4'h5 || s_if.arlen !== 8'd0) begin
      fails++; $display("FAIL err_ar: arid=%0h arlen=%0d want 5/0", s_if.arid, s_if.arlen); end
    @(negedge clk);
    m1_if.arvalid = 0; s_if.arready = 0; m1_if.rready = 1;
    set_beat(32'hDEAD_BEEF, RESP_SLVERR, 1'b1, 4'h5);
    #1;
    tests++; if (m1_if.rvalid !== 1'b1 || m1_if.rresp !== 2'b10 || m1_if.rlast !== 1'b1 || m1_if.rid !== 4'h5) begin
      fails++; $display("FAIL err_beat: rvalid=%0b rresp=%02b rlast=%0b rid=%0h want 1/10/1/5", m1_if.rvalid, m1_if.rresp, m1_if.rlast, m1_if.rid); end
    @(negedge clk);
    s_if.rvalid = 0; s_if.rlast = 0;
    #1;
    tests++; if (dut.state_reg !== ST_IDLE) begin fails++; $display("FAIL err_end_idle: state got %0d want %0d", dut.state_reg, ST_IDLE); end
    $display("[TB] test_err_single: SLVERR single beat to m1");
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1;
    idle_bus();
    test_reset();
    test_m0_only();
    test_tie();
    test_blocked_request();
    test_backpressure();
    test_reset_mid();
    test_err_single();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
